keypad_scanner: RTL and testbench

//  Drives a 4x4 matrix keypad one row at a time and samples the active-low column lines.

---
 rtl/keypad_pkg.sv | 27 ++
 rtl/keypad_scanner_if.sv | 27 ++
 rtl/keypad_debounce.sv | 53 +++++
 rtl/keypad_scanner.sv | 119 +++++++++++
 tb/tb_keypad_scanner.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared constants, FSM encoding and row-hit priority helper for the keypad scanner.
// Pure definitions: no latency, no flow control.
package keypad_pkg;

    localparam int         NUM_ROWS = 4;
    localparam int         NUM_COLS = 4;
    localparam logic [4:0] NO_KEY   = 5'h10;
    localparam logic [3:0] ROW_INIT = 4'b1110;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    // Lowest pressed column wins; the MSB of the result flags "nothing pressed".
    function automatic logic [4:0] row_hit(input logic [1:0] row_idx, input logic [3:0] col_n);
        logic [4:0] code;
        code = NO_KEY;
        for (int c = NUM_COLS - 1; c >= 0; c--) begin
            if (!col_n[c]) begin
                code = {1'b0, row_idx, 2'(c)};
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and key-event signals of the scanner, grouped as one bundle.
// master = scanner (drives rows and key outputs), slave = keypad/consumer side.
interface keypad_scanner_if;

    logic [3:0] column;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  column,
        output row,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output column,
        input  row,
        input  key_code,
        input  key_valid,
        input  key_held
    );

endinterface

// File: rtl/keypad_debounce.sv
// Tracks the candidate scan result and how many consecutive scans agreed on it.
// Outputs show the post-update view during the scan_done cycle; no backpressure.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_scan_done,
    input  logic [4:0] i_result,
    output logic [4:0] o_candidate,
    output logic       o_stable
);

    localparam int            CW      = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

    logic [4:0]    r_candidate;
    logic [CW-1:0] r_db_cnt;
    logic [4:0]    w_cand_nxt;
    logic [CW-1:0] w_cnt_nxt;

    always_comb begin
        w_cand_nxt = r_candidate;
        w_cnt_nxt  = r_db_cnt;
        if (i_scan_done) begin
            if (i_result == r_candidate) begin
                if (r_db_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_db_cnt + 1'b1;
                end
            end else begin
                w_cand_nxt = i_result;
                w_cnt_nxt  = CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_candidate <= NO_KEY;
            r_db_cnt    <= '0;
        end else begin
            r_candidate <= w_cand_nxt;
            r_db_cnt    <= w_cnt_nxt;
        end
    end

    // Exposing the next-state view lets the FSM act in the same scan_done cycle.
    assign o_candidate = w_cand_nxt;
    assign o_stable    = (w_cnt_nxt == CNT_MAX);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with 2-flop column sync, debounce and one-pulse-per-press key FSM.
// key_valid lands 1 cycle after the accepting scan_done; free-running, no backpressure.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.master  kp
);

    localparam int            DW         = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

    logic [3:0]    r_col_meta;
    logic [3:0]    r_col_s;
    logic [DW-1:0] r_dwell;
    logic [1:0]    r_row_idx;
    logic [3:0]    r_row;
    logic [4:0]    r_scan_acc;
    state_t        r_state;
    logic [3:0]    r_key_code;
    logic          r_key_valid;

    logic          w_sample;
    logic          w_scan_done;
    logic [4:0]    w_hit;
    logic [4:0]    w_scan_res;
    logic [4:0]    w_candidate;
    logic          w_stable;
    state_t        w_state_nxt;
    logic [3:0]    w_code_nxt;
    logic          w_valid_nxt;

    assign w_sample    = (r_dwell == DWELL_LAST);
    assign w_scan_done = w_sample && (r_row_idx == 2'(NUM_ROWS - 1));
    assign w_hit       = row_hit(r_row_idx, r_col_s);
    // Row 0 opens a new scan; afterwards the first hit in row order is kept.
    assign w_scan_res  = ((r_row_idx == 2'd0) || (r_scan_acc == NO_KEY)) ? w_hit : r_scan_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_meta <= 4'b1111;
            r_col_s    <= 4'b1111;
            r_dwell    <= '0;
            r_row_idx  <= '0;
            r_row      <= ROW_INIT;
            r_scan_acc <= NO_KEY;
        end else begin
            r_col_meta <= kp.column;
            r_col_s    <= r_col_meta;
            if (w_sample) begin
                r_dwell    <= '0;
                r_row_idx  <= r_row_idx + 1'b1;
                r_row      <= {r_row[2:0], r_row[3]};
                r_scan_acc <= w_scan_res;
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .i_scan_done (w_scan_done),
        .i_result    (w_scan_res),
        .o_candidate (w_candidate),
        .o_stable    (w_stable)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_key_code  <= w_code_nxt;
            r_key_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_key_code;
        w_valid_nxt = 1'b0;
        if (w_scan_done && w_stable) begin
            case (r_state)
                IDLE: begin
                    if (w_candidate != NO_KEY) begin
                        w_state_nxt = HELD;
                        w_code_nxt  = w_candidate[3:0];
                        w_valid_nxt = 1'b1;
                    end
                end
                HELD: begin
                    if (w_candidate == NO_KEY) begin
                        w_state_nxt = IDLE;
                    end else if (w_candidate[3:0] != r_key_code) begin
                        w_code_nxt  = w_candidate[3:0];
                        w_valid_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign kp.row       = r_row;
    assign kp.key_code  = r_key_code;
    assign kp.key_valid = r_key_valid;
    assign kp.key_held  = (r_state == HELD);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad model driven from the row lines, cycle-level reference model,
// directed scenarios with literal expectations followed by randomized key traffic.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DB       = 2;
    localparam int SCAN     = SCAN_DIV * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pressed = 16'h0000;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif)
    );

    always #5 clk = ~clk;

    // A pressed key pulls its column low only while its row is driven low.
    function automatic logic [3:0] cols_for(input logic [3:0] row_n, input logic [15:0] keys);
        logic [3:0] c;
        c = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                if (!row_n[r] && keys[r*4+k]) begin
                    c[k] = 1'b0;
                end
            end
        end
        return c;
    endfunction

    assign kif.column = cols_for(kif.row, pressed);

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: time since reset gives the driven row; column history gives samples.
    int         m_t;
    int         m_cand;
    int         m_cnt;
    int         m_code;
    int         m_rowhit [4];
    logic [3:0] m_s1;
    logic [3:0] m_s2;
    bit         m_held;
    bit         m_valid;
    bit         m_known = 1'b0;

    always @(negedge clk) begin
        int         ridx;
        int         dw;
        int         hit;
        int         result;
        bit         vnext;
        logic [3:0] erow;
        ridx = (m_t / SCAN_DIV) % 4;
        dw   = m_t % SCAN_DIV;
        erow = ~(4'b0001 << ridx);
        if (m_known) begin
            check("row", 32'(kif.row), 32'(erow));
            check("key_code", 32'(kif.key_code), 32'(m_code));
            check("key_valid", 32'(kif.key_valid), 32'(m_valid));
            check("key_held", 32'(kif.key_held), 32'(m_held));
        end
        if (kif.key_valid === 1'b1) pulses++;
        if (rst) begin
            m_t     = 0;
            m_cand  = -1;
            m_cnt   = 0;
            m_code  = 0;
            m_s1    = 4'hF;
            m_s2    = 4'hF;
            m_held  = 1'b0;
            m_valid = 1'b0;
            for (int r = 0; r < 4; r++) m_rowhit[r] = -1;
            m_known = 1'b1;
        end else begin
            vnext = 1'b0;
            if (dw == SCAN_DIV - 1) begin
                hit = -1;
                for (int c = 3; c >= 0; c--) if (!m_s2[c]) hit = ridx * 4 + c;
                m_rowhit[ridx] = hit;
                if (ridx == 3) begin
                    result = -1;
                    for (int r = 0; r < 4; r++) if (result < 0) result = m_rowhit[r];
                    if (result == m_cand) begin
                        if (m_cnt < DB) m_cnt++;
                    end else begin
                        m_cand = result;
                        m_cnt  = 1;
                    end
                    if (m_cnt == DB) begin
                        if (!m_held && m_cand >= 0) begin
                            m_held = 1'b1;
                            m_code = m_cand;
                            vnext  = 1'b1;
                        end else if (m_held && m_cand < 0) begin
                            m_held = 1'b0;
                        end else if (m_held && m_cand != m_code) begin
                            m_code = m_cand;
                            vnext  = 1'b1;
                        end
                    end
                end
            end
            m_s2    = m_s1;
            m_s1    = cols_for(erow, pressed);
            m_t     = m_t + 1;
            m_valid = vnext;
        end
    end

    initial begin
        logic [3:0] row_tbl [4];
        int p0;
        int a;
        int b;
        row_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        rst = 1'b1;
        pressed = 16'h0000;
        cyc(3);
        check("reset_row", 32'(kif.row), 32'(4'b1110));
        check("reset_code", 32'(kif.key_code), 32'd0);
        check("reset_valid", 32'(kif.key_valid), 32'd0);
        check("reset_held", 32'(kif.key_held), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            check("idle_row_seq", 32'(kif.row), 32'(row_tbl[(i / 4) % 4]));
            cyc(1);
        end
        cyc(2 * SCAN);
        check("idle_no_pulse", 32'(pulses), 32'd0);

        p0 = pulses;
        pressed = 16'h0040;
        cyc(5 * SCAN);
        check("r1c2_pulses", 32'(pulses - p0), 32'd1);
        check("r1c2_code", 32'(kif.key_code), 32'd6);
        check("r1c2_held", 32'(kif.key_held), 32'd1);
        check("model_code_r1c2", 32'(m_code), 32'd6);
        pressed = 16'h0000;
        cyc(4 * SCAN);
        check("release_held", 32'(kif.key_held), 32'd0);
        check("release_no_pulse", 32'(pulses - p0), 32'd1);

        p0 = pulses;
        pressed = 16'h1000;
        cyc(SCAN);
        pressed = 16'h0000;
        cyc(4 * SCAN);
        check("bounce_pulses", 32'(pulses - p0), 32'd0);
        check("bounce_held", 32'(kif.key_held), 32'd0);
        check("bounce_code_kept", 32'(kif.key_code), 32'd6);

        p0 = pulses;
        pressed = 16'h0108;
        cyc(5 * SCAN);
        check("two_keys_pulses", 32'(pulses - p0), 32'd1);
        check("two_keys_code", 32'(kif.key_code), 32'd3);
        pressed = 16'h0100;
        cyc(5 * SCAN);
        check("rollover_pulses", 32'(pulses - p0), 32'd2);
        check("rollover_code", 32'(kif.key_code), 32'd8);
        check("rollover_held", 32'(kif.key_held), 32'd1);
        check("model_code_roll", 32'(m_code), 32'd8);
        pressed = 16'h0000;
        cyc(4 * SCAN);

        pressed = 16'h0020;
        cyc(24);
        rst = 1'b1;
        cyc(1);
        check("midrst_row", 32'(kif.row), 32'(4'b1110));
        check("midrst_code", 32'(kif.key_code), 32'd0);
        check("midrst_valid", 32'(kif.key_valid), 32'd0);
        check("midrst_held", 32'(kif.key_held), 32'd0);
        rst = 1'b0;
        p0 = pulses;
        cyc(4 * SCAN);
        check("after_rst_pulses", 32'(pulses - p0), 32'd1);
        check("after_rst_code", 32'(kif.key_code), 32'd5);
        check("after_rst_held", 32'(kif.key_held), 32'd1);
        pressed = 16'h0000;
        cyc(4 * SCAN);

        for (int it = 0; it < 60; it++) begin
            a = $urandom_range(0, 9);
            if (a < 3) begin
                pressed = 16'h0000;
            end else if (a < 8) begin
                pressed = 16'(1) << $urandom_range(0, 15);
            end else begin
                a = $urandom_range(0, 15);
                b = $urandom_range(0, 15);
                pressed = (16'(1) << a) | (16'(1) << b);
            end
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                cyc(1);
                rst = 1'b0;
            end
            cyc($urandom_range(1, 70));
        end
        pressed = 16'h0000;
        cyc(4 * SCAN);
        check("final_held", 32'(kif.key_held), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
